// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and the coordinate widths used by the render stage.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam bit HSYNC_POL = 1'b0;
    localparam bit VSYNC_POL = 1'b0;
    localparam int CLK_DIV   = 1;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // END values are exclusive: sync is asserted for START <= cnt < END.
    localparam int HSYNC_START = H_ACTIVE + H_FP;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC;
    localparam int VSYNC_START = V_ACTIVE + V_FP;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int CNT_W = 10;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter. load_max outranks reset so the raster counters can
// come out of reset parked on their last value, one step before (0,0).
module wrap_counter
    import vga_pkg::*;
#(
    parameter int MAX = 1,
    parameter int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load_max,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE   = W'(1);

    assign wrap = (count == MAX_V);

    always_ff @(posedge clk) begin
        if (load_max)
            count <= MAX_V;
        else if (!rst_n)
            count <= '0;
        else if (inc)
            count <= wrap ? '0 : count + ONE;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: divided pixel tick drives horizontal/vertical counters;
// every output is registered from the post-tick counter values so they move together.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP,
    parameter bit HSYNC_POL = vga_pkg::HSYNC_POL,
    parameter bit VSYNC_POL = vga_pkg::VSYNC_POL,
    parameter int CLK_DIV   = vga_pkg::CLK_DIV
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           active,
    output logic           hsync,
    output logic           vsync,
    output logic           pix_en,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic             tick, h_wrap, v_wrap, h_inc;
    logic             row_act, pix_act, hs_on, vs_on;
    logic             unused_div;

    assign unused_div = ^div_cnt;
    assign h_inc      = tick & h_wrap;

    wrap_counter #(.MAX(CLK_DIV - 1), .W(DIV_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (1'b1),
        .load_max (1'b0),
        .count    (div_cnt),
        .wrap     (tick)
    );

    wrap_counter #(.MAX(H_TOT - 1), .W(CNT_W)) u_hcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (tick),
        .load_max (~rst_n),
        .count    (h_cnt),
        .wrap     (h_wrap)
    );

    wrap_counter #(.MAX(V_TOT - 1), .W(CNT_W)) u_vcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (h_inc),
        .load_max (~rst_n),
        .count    (v_cnt),
        .wrap     (v_wrap)
    );

    // Mirror of the counters' next state so outputs decode the values being loaded.
    always_comb begin
        h_nxt = h_wrap ? '0 : h_cnt + CNT_ONE;
        v_nxt = v_cnt;
        if (h_wrap)
            v_nxt = v_wrap ? '0 : v_cnt + CNT_ONE;
        row_act = (v_nxt < V_ACT_C);
        pix_act = row_act && (h_nxt < H_ACT_C);
        hs_on   = (h_nxt >= HS_LO) && (h_nxt < HS_HI);
        vs_on   = (v_nxt >= VS_LO) && (v_nxt < VS_HI);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= tick;
            line_start  <= tick & h_wrap;
            frame_start <= tick & h_wrap & v_wrap;
            if (tick) begin
                x      <= pix_act ? h_nxt : '0;
                y      <= row_act ? v_nxt[Y_W-1:0] : '0;
                active <= pix_act;
                hsync  <= hs_on ^ ~HSYNC_POL;
                vsync  <= vs_on ^ ~VSYNC_POL;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size timing for one line, reduced timing
// (15x8 raster) at CLK_DIV=1 and 2 for frame-level behaviour and mid-frame reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [9:0] x_o  [3];
    logic [8:0] y_o  [3];
    logic       act_o[3], hs_o[3], vs_o[3], pe_o[3], ls_o[3], fs_o[3];

    vga_timing_gen dut0 (
        .clk(clk), .rst_n(rst_n), .x(x_o[0]), .y(y_o[0]), .active(act_o[0]),
        .hsync(hs_o[0]), .vsync(vs_o[0]), .pix_en(pe_o[0]),
        .line_start(ls_o[0]), .frame_start(fs_o[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .x(x_o[1]), .y(y_o[1]), .active(act_o[1]),
        .hsync(hs_o[1]), .vsync(vs_o[1]), .pix_en(pe_o[1]),
        .line_start(ls_o[1]), .frame_start(fs_o[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .x(x_o[2]), .y(y_o[2]), .active(act_o[2]),
        .hsync(hs_o[2]), .vsync(vs_o[2]), .pix_en(pe_o[2]),
        .line_start(ls_o[2]), .frame_start(fs_o[2])
    );

    // n = clock edges since reset release at which the vector is sampled.
    typedef struct {
        int n;
        int x;
        int y;
        bit act, hs, vs, pe, ls, fs;
    } vec_t;

    vec_t tbl0[11];
    vec_t tbl1[8];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input int k, input vec_t v, input string tag);
        chk({tag, ".x"},      32'(x_o[k]),  32'(v.x));
        chk({tag, ".y"},      32'(y_o[k]),  32'(v.y));
        chk({tag, ".active"}, 32'(act_o[k]), 32'(v.act));
        chk({tag, ".hsync"},  32'(hs_o[k]),  32'(v.hs));
        chk({tag, ".vsync"},  32'(vs_o[k]),  32'(v.vs));
        chk({tag, ".pix_en"}, 32'(pe_o[k]),  32'(v.pe));
        chk({tag, ".line_start"},  32'(ls_o[k]), 32'(v.ls));
        chk({tag, ".frame_start"}, 32'(fs_o[k]), 32'(v.fs));
    endtask

    task automatic chk_reset(input string tag);
        vec_t r;
        r = '{0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++)
            chk_vec(k, r, $sformatf("%s.dut%0d", tag, k));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   vi, act_cnt, hs_low, x_err, ls_period;
        int   ls_n[$];
        int   last_fs1, fs1_cnt, fs1_bad, last_fs2, fs2_cnt, fs2_bad;
        int   vs_start, vs_runs, vs_bad, li, y_bad, inv_bad, pe2_bad, stable_bad, w;
        logic prev_vs1, prev_pe2;
        logic [21:0] snap2;

        tbl0 = '{
            '{1,   0,   0, 1, 1, 1, 1, 1, 1},
            '{2,   1,   0, 1, 1, 1, 1, 0, 0},
            '{640, 639, 0, 1, 1, 1, 1, 0, 0},
            '{641, 0,   0, 0, 1, 1, 1, 0, 0},
            '{656, 0,   0, 0, 1, 1, 1, 0, 0},
            '{657, 0,   0, 0, 0, 1, 1, 0, 0},
            '{752, 0,   0, 0, 0, 1, 1, 0, 0},
            '{753, 0,   0, 0, 1, 1, 1, 0, 0},
            '{800, 0,   0, 0, 1, 1, 1, 0, 0},
            '{801, 0,   1, 1, 1, 1, 1, 1, 0},
            '{802, 1,   1, 1, 1, 1, 1, 0, 0}
        };
        tbl1 = '{
            '{1,  0, 0, 1, 1, 1, 1, 1, 1},
            '{2,  1, 0, 1, 1, 1, 1, 0, 0},
            '{8,  7, 0, 1, 1, 1, 1, 0, 0},
            '{9,  0, 0, 0, 1, 1, 1, 0, 0},
            '{11, 0, 0, 0, 0, 1, 1, 0, 0},
            '{13, 0, 0, 0, 0, 1, 1, 0, 0},
            '{14, 0, 0, 0, 1, 1, 1, 0, 0},
            '{16, 0, 1, 1, 1, 1, 1, 1, 0}
        };

        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;

        // One full-size line plus two pixels of the next.
        vi = 0; act_cnt = 0; hs_low = 0; x_err = 0;
        for (int n = 1; n <= 802; n++) begin
            @(posedge clk);
            #1;
            if (vi < 11 && tbl0[vi].n == n) begin
                chk_vec(0, tbl0[vi], $sformatf("line[%0d]", vi));
                vi++;
            end
            if (n <= 800) begin
                if (act_o[0]) act_cnt++;
                if (!hs_o[0]) hs_low++;
                if (act_o[0] && x_o[0] != 10'(n - 1)) x_err++;
            end
            if (ls_o[0]) ls_n.push_back(n);
            if (n == 1) begin
                chk("div1_first_fs", 32'(fs_o[1]), 1);
                chk("div2_first_pe", 32'(pe_o[2]), 0);
            end
            if (n == 2) begin
                chk("div2_second_fs", 32'(fs_o[2]), 1);
                chk("div2_second_active", 32'(act_o[2]), 1);
            end
        end
        chk("line_vectors_applied", vi, 11);
        chk("line_active_cycles", act_cnt, 640);
        chk("line_hsync_low_cycles", hs_low, 96);
        chk("line_x_ramp_errors", x_err, 0);
        chk("line_start_pulses", ls_n.size(), 2);
        ls_period = (ls_n.size() >= 2) ? ls_n[1] - ls_n[0] : -1;
        chk("line_start_period", ls_period, 800);

        // Frame-level behaviour on the reduced raster.
        last_fs1 = -1; fs1_cnt = 0; fs1_bad = 0; last_fs2 = -1; fs2_cnt = 0; fs2_bad = 0;
        vs_start = -1; vs_runs = 0; vs_bad = 0; li = -1; y_bad = 0;
        inv_bad = 0; pe2_bad = 0; stable_bad = 0;
        prev_vs1 = vs_o[1];
        prev_pe2 = pe_o[2];
        snap2    = {x_o[2], y_o[2], act_o[2], hs_o[2], vs_o[2]};
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (fs_o[1]) begin
                if (last_fs1 >= 0 && c - last_fs1 != 120) fs1_bad++;
                last_fs1 = c;
                fs1_cnt++;
                li = 0;
            end else if (ls_o[1] && li >= 0) begin
                li++;
            end
            if (ls_o[1] && li >= 0 && y_o[1] != 9'((li < 4) ? li : 0)) y_bad++;

            if (prev_vs1 && !vs_o[1]) begin
                vs_start = c;
                if (!ls_o[1]) vs_bad++;
            end
            if (!prev_vs1 && vs_o[1] && vs_start >= 0) begin
                vs_runs++;
                if (c - vs_start != 30) vs_bad++;
            end
            prev_vs1 = vs_o[1];

            if (fs_o[2]) begin
                if (last_fs2 >= 0 && c - last_fs2 != 240) fs2_bad++;
                last_fs2 = c;
                fs2_cnt++;
            end
            if (pe_o[2] == prev_pe2) pe2_bad++;
            if (!pe_o[2] && {x_o[2], y_o[2], act_o[2], hs_o[2], vs_o[2]} != snap2) stable_bad++;
            snap2    = {x_o[2], y_o[2], act_o[2], hs_o[2], vs_o[2]};
            prev_pe2 = pe_o[2];

            for (int k = 1; k < 3; k++) begin
                if (act_o[k] && !(hs_o[k] && vs_o[k])) inv_bad++;
                if (fs_o[k] && !ls_o[k]) inv_bad++;
                if ((ls_o[k] || fs_o[k]) && !pe_o[k]) inv_bad++;
            end
        end
        chk("frame1_starts", fs1_cnt, 9);
        chk("frame1_period_errors", fs1_bad, 0);
        chk("frame2_starts", fs2_cnt, 4);
        chk("frame2_period_errors", fs2_bad, 0);
        chk("vsync_runs", vs_runs, 8);
        chk("vsync_run_errors", vs_bad, 0);
        chk("y_per_line_errors", y_bad, 0);
        chk("div2_strobe_alternation_errors", pe2_bad, 0);
        chk("div2_hold_errors", stable_bad, 0);
        chk("invariant_errors", inv_bad, 0);

        // Mid-frame reset at (h=7, v=2) of the reduced raster.
        w = 0;
        while (!fs_o[1] && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("frame_start_wait_in_budget", 32'(w < 200), 1);
        repeat (37) @(posedge clk);
        #1;
        chk("midframe.x", 32'(x_o[1]), 7);
        chk("midframe.y", 32'(y_o[1]), 2);
        chk("midframe.active", 32'(act_o[1]), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("midreset");
        rst_n = 1'b1;

        vi = 0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            if (vi < 8 && tbl1[vi].n == n) begin
                chk_vec(1, tbl1[vi], $sformatf("restart[%0d]", vi));
                vi++;
            end
            if (n == 1) chk_vec(0, tbl0[0], "restart_full");
            if (n == 2) chk("restart_div2_fs", 32'(fs_o[2]), 1);
        end
        chk("restart_vectors_applied", vi, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
